// File: rtl/apb_timer_slave.sv
// APB3/APB4 timer peripheral: 32-bit down-counter with an 8-bit prescaler,
// one-shot or auto-reload modes, sticky expiry flag and level interrupt.
module apb_timer_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  irq
);

  // Handshake: a transfer completes in the cycle PSEL & PENABLE is high
  // (PREADY is never low then); writes commit on that edge, reads are
  // combinational from registered state, SETUP has no side effects.

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_VALUE  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        exp_q, exp_d;

  logic [2:0]  off;
  logic        access;
  logic        mapped;
  logic        wr_ok;
  logic        ctrl_wr, load_wr, status_wr, presc_wr;
  logic        tick;
  logic        exp_set;
  logic [31:0] load_new;
  logic [31:0] rdata;

  // Address bits outside [4:2] are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = wr_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign off     = PADDR[4:2];
  assign access  = PSEL & PENABLE;
  assign mapped  = (off <= OFF_PRESC);
  assign PREADY  = access;
  assign PSLVERR = access & (~mapped | (PWRITE & (off == OFF_VALUE)));
  assign wr_ok   = access & PWRITE & ~PSLVERR;

  assign ctrl_wr   = wr_ok & (off == OFF_CTRL);
  assign load_wr   = wr_ok & (off == OFF_LOAD);
  assign status_wr = wr_ok & (off == OFF_STATUS);
  assign presc_wr  = wr_ok & (off == OFF_PRESC);

  assign load_new = merge_lanes(load_q, PWDATA[31:0], PSTRB);
  assign tick     = ctrl_q[0] & (pcnt_q == presc_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    value_d = value_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    exp_set = 1'b0;

    if (ctrl_q[0]) begin
      if (tick) begin
        pcnt_d = 8'd0;
        // A LOAD write on a tick edge suppresses that tick's decrement/expiry.
        if (!load_wr) begin
          if (value_q != 32'd0) begin
            value_d = value_q - 32'd1;
          end else begin
            exp_set = 1'b1;
            if (ctrl_q[1]) value_d = load_q;
            else           ctrl_d[0] = 1'b0;
          end
        end
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end else begin
      pcnt_d = 8'd0;
    end

    if (ctrl_wr && PSTRB[0]) begin
      ctrl_d = PWDATA[2:0];
      if (!PWDATA[0]) pcnt_d = 8'd0;
    end

    if (load_wr) begin
      load_d  = load_new;
      value_d = load_new;
      pcnt_d  = 8'd0;
    end

    if (presc_wr && PSTRB[0]) presc_d = PWDATA[7:0];

    // Expiry set takes priority over a simultaneous write-1-to-clear.
    exp_d = (exp_q & ~(status_wr & PSTRB[0] & PWDATA[0])) | exp_set;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      value_q <= 32'd0;
      presc_q <= 8'd0;
      pcnt_q  <= 8'd0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      value_q <= value_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_CTRL:   rdata = {29'd0, ctrl_q};
      OFF_LOAD:   rdata = load_q;
      OFF_VALUE:  rdata = value_q;
      OFF_STATUS: rdata = {31'd0, exp_q};
      OFF_PRESC:  rdata = {24'd0, presc_q};
      default:    rdata = 32'd0;
    endcase
  end

  assign PRDATA = (PSEL & ~PWRITE) ? rdata : '0;
  assign irq    = exp_q & ctrl_q[2];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: register access, one-shot and
// auto-reload counting, byte strobes, error responses and edge collisions.
module tb_apb_timer_slave;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  // Clock and watchdog
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: called at (posedge + 1); return at (commit edge + 1).
  task automatic apb_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = addr; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    check({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
    check({tag, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
  endtask

  task automatic apb_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    check({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
    check({tag, "_prdata"}, PRDATA, exp_data);
    check({tag, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_val;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0; PSTRB = 4'h0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset values
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_pready_idle", {31'd0, PREADY}, 32'd0);
    apb_read("rst_ctrl",   32'h00, 32'd0, 1'b0);
    apb_read("rst_load",   32'h04, 32'd0, 1'b0);
    apb_read("rst_value",  32'h08, 32'd0, 1'b0);
    apb_read("rst_status", 32'h0C, 32'd0, 1'b0);
    apb_read("rst_presc",  32'h10, 32'd0, 1'b0);

    // One-shot: LOAD=5, PRESC=0, CTRL=EN|IE -> expiry 6 cycles after CTRL edge
    apb_write("os_load",  32'h04, 32'd5, 4'hF, 1'b0);
    apb_write("os_presc", 32'h10, 32'd0, 4'hF, 1'b0);
    apb_write("os_ctrl",  32'h00, 32'h5, 4'hF, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge PCLK); #1;
      check($sformatf("os_irq_c%0d", k), {31'd0, irq}, (k == 6) ? 32'd1 : 32'd0);
    end
    apb_read("os_ctrl_after",   32'h00, 32'h4, 1'b0);
    apb_read("os_value_after",  32'h08, 32'd0, 1'b0);
    apb_read("os_status_after", 32'h0C, 32'd1, 1'b0);
    apb_write("os_w1c", 32'h0C, 32'd1, 4'hF, 1'b0);
    apb_read("os_status_clr", 32'h0C, 32'd0, 1'b0);
    check("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: LOAD=2, PRESC=3, CTRL=EN|AUTO; observed via SETUP-phase reads
    apb_write("ar_load",  32'h04, 32'd2, 4'hF, 1'b0);
    apb_write("ar_presc", 32'h10, 32'd3, 4'hF, 1'b0);
    apb_write("ar_ctrl",  32'h00, 32'h3, 4'hF, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge PCLK); #1;
      exp_val = (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : (k < 12) ? 32'd0 : 32'd2;
      PADDR = 32'h08; #1;
      check($sformatf("ar_value_c%0d", k), PRDATA, exp_val);
      PADDR = 32'h0C; #1;
      check($sformatf("ar_exp_c%0d", k), PRDATA, (k >= 12) ? 32'd1 : 32'd0);
    end
    PSEL = 1'b0;
    check("ar_irq_no_ie", {31'd0, irq}, 32'd0);
    apb_write("ar_w1c", 32'h0C, 32'd1, 4'hF, 1'b0);
    apb_read("ar_status_clr", 32'h0C, 32'd0, 1'b0);
    apb_write("ar_stop", 32'h00, 32'd0, 4'hF, 1'b0);

    // Byte strobes
    apb_write("bs_load0", 32'h04, 32'd0, 4'hF, 1'b0);
    apb_write("bs_load",  32'h04, 32'hAABBCCDD, 4'b0101, 1'b0);
    apb_read("bs_load_rd",  32'h04, 32'h00BB00DD, 1'b0);
    apb_read("bs_value_rd", 32'h08, 32'h00BB00DD, 1'b0);

    // Error responses
    apb_write("err_wr_value", 32'h08, 32'h1234, 4'hF, 1'b1);
    apb_read("err_value_kept", 32'h08, 32'h00BB00DD, 1'b0);
    apb_read("err_rd_18", 32'h18, 32'd0, 1'b1);
    apb_write("err_wr_14", 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1);
    apb_read("ok_rd_04", 32'h04, 32'h00BB00DD, 1'b0);

    // Collision: W1C of EXP on the expiry edge -> EXP stays 1
    apb_write("c1_load",  32'h04, 32'd3, 4'hF, 1'b0);
    apb_write("c1_presc", 32'h10, 32'd0, 4'hF, 1'b0);
    apb_write("c1_ctrl",  32'h00, 32'h1, 4'hF, 1'b0);
    repeat (2) @(posedge PCLK);
    #1;
    apb_write("c1_w1c", 32'h0C, 32'd1, 4'hF, 1'b0);
    apb_read("c1_status", 32'h0C, 32'd1, 1'b0);
    apb_read("c1_ctrl_rd", 32'h00, 32'd0, 1'b0);
    apb_write("c1_w1c2", 32'h0C, 32'd1, 4'hF, 1'b0);
    apb_read("c1_status_clr", 32'h0C, 32'd0, 1'b0);

    // Collision: LOAD=9 written on a tick edge -> VALUE 9, then 8 next tick
    apb_write("c2_load20", 32'h04, 32'd20, 4'hF, 1'b0);
    apb_write("c2_ctrl",   32'h00, 32'h3, 4'hF, 1'b0);
    apb_write("c2_load9",  32'h04, 32'd9, 4'hF, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h08;
    #1;
    check("c2_value_9", PRDATA, 32'd9);
    @(posedge PCLK); #1;
    check("c2_value_8", PRDATA, 32'd8);
    PSEL = 1'b0;
    apb_write("c2_stop", 32'h00, 32'd0, 4'hF, 1'b0);

    // LOAD=0 with AUTO expires every tick; then reset mid-count
    apb_write("rm_load",  32'h04, 32'd0, 4'hF, 1'b0);
    apb_write("rm_presc", 32'h10, 32'd2, 4'hF, 1'b0);
    apb_write("rm_ctrl",  32'h00, 32'h7, 4'hF, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge PCLK); #1;
      check($sformatf("rm_irq_c%0d", k), {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
    end
    PRESET = 1'b1;
    #1;
    check("rm_irq_reset", {31'd0, irq}, 32'd0);
    apb_write("rm_wr_in_reset", 32'h04, 32'h55, 4'hF, 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read("rm_ctrl_rd",   32'h00, 32'd0, 1'b0);
    apb_read("rm_load_rd",   32'h04, 32'd0, 1'b0);
    apb_read("rm_value_rd",  32'h08, 32'd0, 1'b0);
    apb_read("rm_status_rd", 32'h0C, 32'd0, 1'b0);
    apb_read("rm_presc_rd",  32'h10, 32'd0, 1'b0);
    check("rm_irq_after", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB3/APB4 timer peripheral that sits downstream of the system APB master. It is selected by that master's PSEL_TIMER output.
- Provides a 32-bit down-counter with an 8-bit prescaler, one-shot or auto-reload modes, a sticky expiry flag and a level interrupt.
- Register access uses zero-wait-state APB transfers with byte strobes and PSLVERR on illegal accesses.

Parameters:
- ADDR_WIDTH, 32, APB address width; only PADDR[4:2] is decoded.
- DATA_WIDTH, 32, APB data width; fixed at 32 for this block.

Ports:
- PCLK  input  1  APB clock; single clock domain.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select (driven by master PSEL_TIMER).
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  4  byte-lane write strobes.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  transfer error, valid while PREADY=1.
- irq  output  1  interrupt, = STATUS.EXP & CTRL.IE.

Behaviour:
- Reset (async assert, synchronous deassert at the next PCLK edge):
  - CTRL, LOAD, VALUE, PRESC, prescaler counter and STATUS are all 0.
  - PRDATA=0, PSLVERR=0, irq=0.
- Register map, offset = PADDR[4:0]; bits [1:0] are ignored and upper bits are ignored:
  - 0x00 CTRL (RW): [0] EN, [1] AUTO reload, [2] IE; other bits read 0.
  - 0x04 LOAD (RW): 32-bit reload value.
  - 0x08 VALUE (RO): current count.
  - 0x0C STATUS: [0] EXP, write-1-to-clear.
  - 0x10 PRESC (RW): [7:0] divide-minus-one.
  - Offsets 0x14–0x1C are unmapped.
- APB handshake:
  - PREADY = PSEL & PENABLE, combinational, so there are no wait states.
  - A write commits on the PCLK edge where PSEL & PENABLE & PWRITE. Each byte lane is updated only where PSTRB[i]=1.
  - Reads: PRDATA = selected register while PSEL & !PWRITE; otherwise 0.
  - A SETUP phase (PSEL=1, PENABLE=0) has no side effects.
- PSLVERR = PSEL & PENABLE & (unmapped offset | write to VALUE). An erroring write changes no state.
- Writing LOAD (any lane) also copies the resulting LOAD value into VALUE and clears the prescaler counter, in the same edge.
- Counting, only while CTRL.EN=1:
  - The prescaler counter increments each PCLK.
  - A tick occurs when the counter equals PRESC; the counter then returns to 0.
  - With PRESC=0 there is a tick every cycle.
  - On a tick with VALUE>0: VALUE decrements by 1.
  - On a tick with VALUE=0: STATUS.EXP is set. If CTRL.AUTO=1, VALUE reloads from LOAD. If CTRL.AUTO=0, CTRL.EN clears and VALUE stays 0.
- EN cleared by software: the prescaler counter resets to 0 and VALUE holds.
- Simultaneous events:
  - An expiry set and a W1C of EXP on the same edge: the set wins, so EXP stays 1.
  - A LOAD write and a tick on the same edge: the LOAD write wins, and no decrement or expiry happens that cycle.
  - A CTRL write clearing EN and an expiry on the same edge: EN=0 and EXP is set.
- Wrap-around:
  - VALUE never underflows below 0.
  - LOAD=0 with AUTO=1 expires on every tick.
  - The expiry period is (LOAD+1)*(PRESC+1) cycles from EN rising.
- irq is combinational from registered state. It follows EXP and IE with no extra latency.
- Reset asserted mid-transfer: all state clears immediately. PREADY still follows PSEL & PENABLE, and a transfer in flight while reset is asserted has no effect.

Test Plan:
- Reset values: PRESET pulse mid-count, then read each of 0x00–0x10 → all read 0, PSLVERR=0, irq=0.
- One-shot expiry: write LOAD=5, PRESC=0, CTRL=0x5, then count cycles.
  - EXP and irq rise exactly 6 cycles after the CTRL write edge.
  - CTRL reads 0x4 afterwards and VALUE reads 0.
- Auto-reload with prescaler: LOAD=2, PRESC=3, CTRL=0x3.
  - VALUE steps 2,1,0,2 every 4 cycles.
  - EXP is set at cycle 12.
  - Writing STATUS=0x1 clears EXP.
- Byte strobes: write LOAD=0xAABBCCDD with PSTRB=4'b0101 over LOAD=0 → LOAD and VALUE read 0x00BB00DD.
- Errors:
  - Write to 0x08 → PSLVERR=1, VALUE unchanged.
  - Read of 0x18 → PSLVERR=1, PRDATA=0.
  - Read of 0x04 → PSLVERR=0.
- Collisions:
  - W1C of EXP on the exact expiry edge → EXP reads 1.
  - LOAD=9 write on a tick edge → VALUE reads 9, with no decrement that cycle.
